// File: rtl/signed_accumulator_pkg.sv
// Shared constants for the signed accumulator: FSM state encoding and
// default operand/count widths.
package signed_accumulator_pkg;

  localparam int SA_N_DEFAULT  = 4;
  localparam int SA_CW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } sa_state_t;

endpackage

// File: rtl/signed_accumulator_addsub.sv
// n-bit two's-complement adder/subtractor with carry-out and signed overflow.
// Subtraction is performed as x + ~y + 1.
module adder_subtractor_with_overflow #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         over_flow
);

  logic [n-1:0] w_y_eff;
  logic [n:0]   w_sum;

  // Operand conditioning and the single wide add that yields sum and carry
  always_comb begin
    w_y_eff   = add_n ? ~y : y;
    w_sum     = {1'b0, x} + {1'b0, w_y_eff} + {{n{1'b0}}, add_n};
    s         = w_sum[n-1:0];
    c_out     = w_sum[n];
    // Overflow when both addends share a sign and the sum's sign differs
    over_flow = (x[n-1] == w_y_eff[n-1]) && (w_sum[n-1] != x[n-1]);
  end

endmodule

// File: rtl/signed_accumulator.sv
// Sequenced signed accumulator: start opens a sequence, operands are added or
// subtracted one per cycle, the operand marked last closes it and the result
// is held with out_valid until the consumer accepts it.
module signed_accumulator
  import signed_accumulator_pkg::*;
#(
  parameter int n  = SA_N_DEFAULT,
  parameter int cw = SA_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  operand,
  input  logic          add_n,
  input  logic          last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  result,
  output logic          c_out,
  output logic          over_flow,
  output logic [cw-1:0] count
);

  sa_state_t     r_state;
  logic [n-1:0]  r_acc;
  logic          r_c_out;
  logic          r_over_flow;
  logic [cw-1:0] r_count;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [n-1:0]  w_sum;
  logic          w_c_out;
  logic          w_over_flow;

  adder_subtractor_with_overflow #(.n(n)) u_addsub (
    .x         (r_acc),
    .y         (operand),
    .add_n     (add_n),
    .s         (w_sum),
    .c_out     (w_c_out),
    .over_flow (w_over_flow)
  );

  // Sequence FSM with accumulator, flags, operand count and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_c_out     <= 1'b0;
      r_over_flow <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_c_out     <= 1'b0;
            r_over_flow <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            r_acc       <= w_sum;
            r_c_out     <= w_c_out;
            r_over_flow <= r_over_flow | w_over_flow;
            // Count saturates rather than wrapping on long sequences
            if (r_count != {cw{1'b1}}) begin
              r_count <= r_count + {{(cw-1){1'b0}}, 1'b1};
            end
            if (last) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_acc;
  assign c_out     = r_c_out;
  assign over_flow = r_over_flow;
  assign count     = r_count;

endmodule

// File: doc/signed_accumulator.md
SIGNED_ACCUMULATOR -- requirements
Module: signed_accumulator

Interface
REQ-001 SHALL have parameter n, default 4, meaning operand/accumulator width in bits (n >= 2).
REQ-002 SHALL have parameter cw, default 4, meaning operand-count width in bits.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that clears the accumulator and opens a new accumulation.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 operand  input  n  two's-complement operand.
REQ-009 add_n  input  1  0 = add operand, 1 = subtract operand; qualified by in_valid.
REQ-010 last  input  1  marks the final operand of the sequence; qualified by in_valid.
REQ-011 out_valid  output  1  final result available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 result  output  n  accumulator value.
REQ-014 c_out  output  1  carry-out of the most recent accepted operation.
REQ-015 over_flow  output  1  sticky signed overflow for the current sequence.
REQ-016 count  output  cw  number of operands accepted in the current sequence.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-018 IDLE: in_ready=0, out_valid=0; on start=1, go to ACCUM and clear the accumulator, c_out, over_flow and count.
REQ-019 ACCUM: in_ready=1, out_valid=0; an operand is accepted when in_valid=1 in that cycle.
REQ-020 On acceptance: accumulator <= accumulator +/- operand, modulo 2^n (wrap-around, no saturation).
REQ-021 On acceptance: c_out <= carry-out of that operation (subtract = accumulator + ~operand + 1).
REQ-022 On acceptance: over_flow <= over_flow OR the signed overflow of that operation.
REQ-023 On acceptance: count increments and saturates at 2^cw-1.
REQ-024 An operand accepted with last=1 SHALL cause a transition to DONE in the same edge.
REQ-025 DONE: out_valid=1, in_ready=0; result, c_out, over_flow and count SHALL hold stable until out_ready=1, then go to IDLE.
REQ-026 result, c_out, over_flow and count SHALL retain their values in IDLE until the next start.
REQ-027 start in ACCUM or DONE SHALL be ignored.
REQ-028 Latency: result reflects an accepted operand on the following cycle; with in_valid held high, throughput is one operand per cycle.
REQ-029 A single-operand sequence (in_valid and last high in the first ACCUM cycle) SHALL be legal.

Reset
REQ-030 While rst_n=0, all state SHALL clear asynchronously: FSM=IDLE, result=0, c_out=0, over_flow=0, count=0, in_ready=0, out_valid=0.
REQ-031 A reset in any state SHALL abandon the sequence in progress; no partial result is presented afterwards.

Structure
REQ-032 The arithmetic SHALL be a single instance of the existing adder_subtractor_with_overflow (parameter n) with x=accumulator, y=operand, add_n=add_n; its s, c_out and over_flow feed the registers.
REQ-033 FSM state encodings and the n/cw defaults SHALL be defined once as shared constants in a package/include file; there is no other sub-module.

Verification
REQ-034 n=4: start; 3 (add); 4 (add, last) -> out_valid, result=0111, over_flow=0, count=2.
REQ-035 n=4: start; 5 (add); 4 (add, last) -> result=1001, over_flow=1, c_out=0.
REQ-036 n=4: start; 7 (add); 1 (add); 1 (sub, last) -> result=0111, over_flow=1 (sticky), c_out=1.
REQ-037 n=4: start; 0 (sub 1, last) -> result=1111, c_out=0, over_flow=0; hold out_ready=0 for 3 cycles -> outputs stable, out_valid=1; then out_ready=1 -> IDLE.
REQ-038 In ACCUM after 2 operands, drop rst_n -> all outputs 0 immediately, IDLE; in_valid pulses without start -> no change.
REQ-039 Back-to-back in_valid for 16 operands with cw=4 -> count saturates at 15; a start pulse during DONE -> ignored.
